// File: rtl/dram_sim_responder_if.sv
// FIFO-style DRAM command/data bus between the ORAM core (master) and the memory side (slave).
interface dram_sim_responder_if #(
    parameter int DDRAWidth = 28,
    parameter int DDRCWidth = 3,
    parameter int BEDWidth  = 64
);
    localparam int MaskWidth = BEDWidth / 8;

    logic [DDRAWidth-1:0] DRAMAddress;
    logic [DDRCWidth-1:0] DRAMCommand;
    logic                 DRAMCommandValid;
    logic                 DRAMCommandReady;
    logic [BEDWidth-1:0]  DRAMWriteData;
    logic [MaskWidth-1:0] DRAMWriteMask;
    logic                 DRAMWriteDataValid;
    logic                 DRAMWriteDataReady;
    logic [BEDWidth-1:0]  DRAMReadData;
    logic                 DRAMReadDataValid;
    logic                 BadCommand;

    modport master (
        output DRAMAddress,
        output DRAMCommand,
        output DRAMCommandValid,
        input  DRAMCommandReady,
        output DRAMWriteData,
        output DRAMWriteMask,
        output DRAMWriteDataValid,
        input  DRAMWriteDataReady,
        input  DRAMReadData,
        input  DRAMReadDataValid,
        input  BadCommand
    );

    modport slave (
        input  DRAMAddress,
        input  DRAMCommand,
        input  DRAMCommandValid,
        output DRAMCommandReady,
        input  DRAMWriteData,
        input  DRAMWriteMask,
        input  DRAMWriteDataValid,
        output DRAMWriteDataReady,
        output DRAMReadData,
        output DRAMReadDataValid,
        output BadCommand
    );
endinterface

// File: rtl/dram_sim_responder.sv
// Block-RAM backed stand-in for the DDR controller: accepts burst write/read commands
// and returns read beats a fixed number of cycles after they are issued to the array.
module dram_sim_responder #(
    parameter int DDRAWidth   = 28,
    parameter int DDRCWidth   = 3,
    parameter int DDRDWidth   = 512,
    parameter int BEDWidth    = 64,
    parameter int MemAW       = 10,
    parameter int ReadLatency = 4
) (
    input  logic Clock,
    input  logic Reset,
    dram_sim_responder_if.slave bus
);
    localparam int B         = DDRDWidth / BEDWidth;
    localparam int MaskWidth = BEDWidth / 8;
    localparam int BeatW     = (B > 1) ? $clog2(B) : 1;
    localparam int Depth     = 2 ** MemAW;

    localparam logic [BeatW-1:0]     LastBeat = BeatW'(B - 1);
    localparam logic [DDRCWidth-1:0] CmdWrite = DDRCWidth'(0);
    localparam logic [DDRCWidth-1:0] CmdRead  = DDRCWidth'(1);

    typedef enum logic [1:0] {
        Idle,
        Write,
        Read
    } state_t;

    state_t               r_state;
    logic [MemAW-1:0]     r_addr;
    logic [BeatW-1:0]     r_beat;
    logic                 r_cmdReady;
    logic                 r_wrReady;
    logic                 r_badCmd;
    logic [ReadLatency-1:0] r_rdValid;
    logic [BEDWidth-1:0]  r_rdData [ReadLatency];
    logic [BEDWidth-1:0]  r_mem [Depth];

    logic             w_cmdFire;
    logic             w_wrFire;
    logic             w_rdIssue;
    logic             w_lastBeat;
    logic [MemAW-1:0] w_wordAddr;
    logic             w_unusedAddrBits;

    assign w_cmdFire  = bus.DRAMCommandValid & r_cmdReady;
    assign w_wrFire   = bus.DRAMWriteDataValid & r_wrReady;
    assign w_rdIssue  = (r_state == Read);
    assign w_lastBeat = (r_beat == LastBeat);
    assign w_wordAddr = r_addr + MemAW'(r_beat);

    // Upper address bits are deliberately dropped so bursts wrap around the array.
    assign w_unusedAddrBits = ^bus.DRAMAddress[DDRAWidth-1:MemAW];

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_state    <= Idle;
            r_addr     <= '0;
            r_beat     <= '0;
            r_cmdReady <= 1'b1;
            r_wrReady  <= 1'b0;
            r_badCmd   <= 1'b0;
        end else begin
            case (r_state)
                Idle: begin
                    if (w_cmdFire) begin
                        r_addr <= bus.DRAMAddress[MemAW-1:0];
                        r_beat <= '0;
                        if (bus.DRAMCommand == CmdWrite) begin
                            r_state    <= Write;
                            r_cmdReady <= 1'b0;
                            r_wrReady  <= 1'b1;
                        end else if (bus.DRAMCommand == CmdRead) begin
                            r_state    <= Read;
                            r_cmdReady <= 1'b0;
                        end else begin
                            r_badCmd <= 1'b1;
                        end
                    end
                end
                Write: begin
                    if (w_wrFire) begin
                        r_beat <= r_beat + 1'b1;
                        if (w_lastBeat) begin
                            r_state    <= Idle;
                            r_wrReady  <= 1'b0;
                            r_cmdReady <= 1'b1;
                        end
                    end
                end
                Read: begin
                    r_beat <= r_beat + 1'b1;
                    if (w_lastBeat) begin
                        r_state    <= Idle;
                        r_cmdReady <= 1'b1;
                    end
                end
                default: begin
                    r_state    <= Idle;
                    r_cmdReady <= 1'b1;
                    r_wrReady  <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_rdValid <= '0;
        end else begin
            r_rdValid[0] <= w_rdIssue;
            for (int s = 1; s < ReadLatency; s++) begin
                r_rdValid[s] <= r_rdValid[s-1];
            end
        end
    end

    // Array and data pipeline carry no reset so they map onto block RAM and plain flops.
    always_ff @(posedge Clock) begin
        if (w_wrFire) begin
            for (int b = 0; b < MaskWidth; b++) begin
                if (!bus.DRAMWriteMask[b]) begin
                    r_mem[w_wordAddr][b*8 +: 8] <= bus.DRAMWriteData[b*8 +: 8];
                end
            end
        end
        r_rdData[0] <= r_mem[w_wordAddr];
        for (int s = 1; s < ReadLatency; s++) begin
            r_rdData[s] <= r_rdData[s-1];
        end
    end

    assign bus.DRAMCommandReady   = r_cmdReady & ~Reset;
    assign bus.DRAMWriteDataReady = r_wrReady;
    assign bus.DRAMReadDataValid  = r_rdValid[ReadLatency-1];
    assign bus.DRAMReadData       = r_rdValid[ReadLatency-1] ? r_rdData[ReadLatency-1] : '0;
    assign bus.BadCommand         = r_badCmd;
endmodule

// File: tb/tb_dram_sim_responder.sv
// Randomized scoreboard bench for dram_sim_responder: a word-array model predicts every
// read beat and the cycle it must appear in; a separate monitor pops and compares.
module tb_dram_sim_responder;
    localparam int B     = 8;
    localparam int RL    = 4;
    localparam int Depth = 1024;

    typedef struct {
        logic [63:0] data;
        int          cyc;
    } beat_t;

    logic Clock = 1'b0;
    logic Reset;

    always #5 Clock = ~Clock;

    dram_sim_responder_if bus ();

    dram_sim_responder dut (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (bus)
    );

    beat_t       expQ[$];
    logic [63:0] model [Depth];
    logic [63:0] wrData [B];
    logic [7:0]  wrMask [B];
    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;

    always @(posedge Clock) cyc++;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic failTimeout(input string name);
        compared++;
        mismatched++;
        $display("[TB] FAIL %s: got timeout, expected DUT response", name);
    endtask

    // Monitor: every valid beat must match the head of the expected queue, in data and cycle.
    initial begin
        beat_t e;
        forever begin
            @(negedge Clock);
            if (!Reset && bus.DRAMReadDataValid) begin
                if (expQ.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("[TB] FAIL rd_unexpected: got beat 0x%0h at cycle %0d, expected none",
                             bus.DRAMReadData, cyc);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("rd_data", bus.DRAMReadData, e.data);
                    checkOutput("rd_cycle", 64'(cyc), 64'(e.cyc));
                end
            end
        end
    end

    // Issues one command; returns the cycle it was accepted in, or -1 on timeout.
    task automatic applyStimulus(input logic [2:0] cmd, input logic [27:0] addr, output int acceptCyc);
        int budget;
        budget    = 0;
        acceptCyc = -1;
        bus.DRAMCommand      = cmd;
        bus.DRAMAddress      = addr;
        bus.DRAMCommandValid = 1'b1;
        while (acceptCyc < 0 && budget < 50) begin
            @(negedge Clock);
            if (bus.DRAMCommandReady) acceptCyc = cyc;
            @(posedge Clock);
            #1;
            budget++;
        end
        bus.DRAMCommandValid = 1'b0;
        if (acceptCyc < 0) failTimeout("cmd_accept");
    endtask

    // gapMode: 0 continuous valid, 1 valid every other cycle, 2 random valid.
    task automatic writeBurst(input logic [27:0] addr, input int gapMode);
        int T;
        int beat;
        int budget;
        int idx;
        bit toggle;
        beat   = 0;
        budget = 0;
        toggle = 1'b1;
        applyStimulus(3'b000, addr, T);
        if (T < 0) return;
        while (beat < B && budget < 200) begin
            bus.DRAMWriteData      = wrData[beat];
            bus.DRAMWriteMask      = wrMask[beat];
            bus.DRAMWriteDataValid = (gapMode == 0) ? 1'b1 :
                                     (gapMode == 1) ? toggle : ($urandom_range(0, 9) < 7);
            @(negedge Clock);
            if (bus.DRAMWriteDataValid && bus.DRAMWriteDataReady) begin
                idx = (int'(addr[9:0]) + beat) % Depth;
                for (int b = 0; b < 8; b++) begin
                    if (!wrMask[beat][b]) model[idx][b*8 +: 8] = wrData[beat][b*8 +: 8];
                end
                beat++;
            end else if (gapMode == 1 && !bus.DRAMWriteDataValid) begin
                checkOutput("wr_ready_stall", 64'(bus.DRAMWriteDataReady), 64'd1);
            end
            @(posedge Clock);
            #1;
            toggle = ~toggle;
            budget++;
        end
        bus.DRAMWriteDataValid = 1'b0;
        if (beat < B) failTimeout("wr_beats");
    endtask

    task automatic readBurst(input logic [27:0] addr, output int T);
        beat_t e;
        applyStimulus(3'b001, addr, T);
        if (T < 0) return;
        for (int i = 0; i < B; i++) begin
            e.data = model[(int'(addr[9:0]) + i) % Depth];
            e.cyc  = T + 1 + i + RL;
            expQ.push_back(e);
        end
    endtask

    task automatic waitDrain();
        int budget;
        budget = 0;
        while (expQ.size() != 0 && budget < 100) begin
            @(posedge Clock);
            #1;
            budget++;
        end
        if (expQ.size() != 0) begin
            failTimeout("rd_drain");
            expQ.delete();
        end
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got no completion, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int T;
        int T2;
        bus.DRAMAddress        = '0;
        bus.DRAMCommand        = '0;
        bus.DRAMCommandValid   = 1'b0;
        bus.DRAMWriteData      = '0;
        bus.DRAMWriteMask      = '0;
        bus.DRAMWriteDataValid = 1'b0;
        Reset = 1'b1;

        repeat (3) @(posedge Clock);
        @(negedge Clock);
        checkOutput("rst_cmd_ready", 64'(bus.DRAMCommandReady), 64'd0);
        checkOutput("rst_rd_valid", 64'(bus.DRAMReadDataValid), 64'd0);
        checkOutput("rst_rd_data", bus.DRAMReadData, 64'd0);
        checkOutput("rst_wr_ready", 64'(bus.DRAMWriteDataReady), 64'd0);
        checkOutput("rst_bad_cmd", 64'(bus.BadCommand), 64'd0);
        @(posedge Clock);
        #1;
        Reset = 1'b0;
        @(negedge Clock);
        checkOutput("post_rst_cmd_ready", 64'(bus.DRAMCommandReady), 64'd1);
        checkOutput("post_rst_rd_valid", 64'(bus.DRAMReadDataValid), 64'd0);

        // Write data offered with no command must be refused.
        @(posedge Clock);
        #1;
        bus.DRAMWriteData      = 64'hDEAD_BEEF_DEAD_BEEF;
        bus.DRAMWriteDataValid = 1'b1;
        repeat (2) @(posedge Clock);
        @(negedge Clock);
        checkOutput("idle_wr_ready", 64'(bus.DRAMWriteDataReady), 64'd0);
        @(posedge Clock);
        #1;
        bus.DRAMWriteDataValid = 1'b0;

        // Plain write then read at 0x10.
        for (int i = 0; i < B; i++) begin
            wrData[i] = 64'h1000 + 64'(i);
            wrMask[i] = 8'h00;
        end
        writeBurst(28'h10, 0);
        readBurst(28'h10, T);
        waitDrain();

        // Masked first beat: low four bytes must keep their old contents.
        wrData[0] = 64'hFFFF_FFFF_FFFF_FFFF;
        wrMask[0] = 8'h0F;
        for (int i = 1; i < B; i++) begin
            wrData[i] = 64'h2000 + 64'(i);
            wrMask[i] = 8'h00;
        end
        writeBurst(28'h10, 0);
        readBurst(28'h10, T);
        waitDrain();

        // Wrapping write with valid gaps; 0x000 is pre-filled so beats 4-7 are all defined.
        for (int i = 0; i < B; i++) begin
            wrData[i] = 64'h5000 + 64'(i);
            wrMask[i] = 8'h00;
        end
        writeBurst(28'h000, 0);
        for (int i = 0; i < B; i++) wrData[i] = 64'h3000 + 64'(i);
        writeBurst(28'hABC_03FC, 1);
        readBurst(28'h3FC, T);
        waitDrain();
        readBurst(28'h000, T);
        waitDrain();

        // Unsupported command sets the sticky flag and leaves the FSM idle.
        applyStimulus(3'b111, 28'h10, T);
        @(negedge Clock);
        checkOutput("bad_cmd_flag", 64'(bus.BadCommand), 64'd1);
        checkOutput("bad_cmd_ready", 64'(bus.DRAMCommandReady), 64'd1);
        checkOutput("bad_cmd_wr_ready", 64'(bus.DRAMWriteDataReady), 64'd0);
        repeat (3) @(posedge Clock);
        #1;

        // Back-to-back reads at minimum spacing.
        readBurst(28'h10, T);
        readBurst(28'h3FC, T2);
        checkOutput("cmd_spacing", 64'(T2 - T), 64'(B + 1));
        waitDrain();
        checkOutput("bad_cmd_sticky", 64'(bus.BadCommand), 64'd1);

        // Fill the whole array, then run random traffic anywhere in it.
        for (int base = 0; base < Depth; base += B) begin
            for (int i = 0; i < B; i++) begin
                wrData[i] = {$urandom, $urandom};
                wrMask[i] = 8'h00;
            end
            writeBurst(28'(base), 0);
        end
        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 1) == 1) begin
                for (int i = 0; i < B; i++) begin
                    wrData[i] = {$urandom, $urandom};
                    wrMask[i] = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 255)) : 8'h00;
                end
                writeBurst(28'($urandom), 2);
            end else begin
                readBurst(28'($urandom), T);
            end
            repeat ($urandom_range(0, 2)) begin
                @(posedge Clock);
                #1;
            end
        end
        waitDrain();

        // Reset two cycles into a read: nothing may come out, array must survive.
        applyStimulus(3'b001, 28'h10, T);
        @(posedge Clock);
        #1;
        Reset = 1'b1;
        expQ.delete();
        #1;
        checkOutput("mid_rst_rd_valid", 64'(bus.DRAMReadDataValid), 64'd0);
        checkOutput("mid_rst_bad_cmd", 64'(bus.BadCommand), 64'd0);
        repeat (2) @(posedge Clock);
        #1;
        Reset = 1'b0;
        @(negedge Clock);
        checkOutput("mid_rst_cmd_ready", 64'(bus.DRAMCommandReady), 64'd1);
        repeat (20) @(posedge Clock);
        #1;
        readBurst(28'h10, T);
        waitDrain();
        readBurst(28'h3F8, T);
        waitDrain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
